timer_count_gen: RTL and testbench
==================================

# timer_count_gen

Generates the two one-hot values shown on the left four digits of the seven-segment display: a 0–20 elapsed-tick timer (`timer_out`) and a 0–20 debounced key-press count (`count_out`). It sits directly upstream of the display driver and shares its `clk` and `button`. Bit *i* set in either output means value *i*. A start button begins a run. The timer advances one step per tick and stops at 20. Key presses are counted only while the run is active.

## Interface
- `TICK_CYCLES`, default 10_000_000: clock cycles per timer step.
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a raw key level must stay stable before it is accepted.
- `MAX_VAL`, default 20: terminal value for both outputs. Fixed by the 21-bit output width; must not be changed.
- `clk` in 1: system clock. The only clock.
- `rst` in 1: reset, asynchronous, active-low. Clears all state immediately; released synchronously by the board.
- `button` in 1: start/restart request, level. Already clean.
- `key_in` in 1: raw mechanical key to be counted. Asynchronous and bouncy.
- `timer_out` out 21: one-hot timer value.
- `count_out` out 21: one-hot key count.
- `done` out 1: high while in DONE.

## Operation
- **Reset values** (`rst`=0): `timer_out`=21'h1, `count_out`=21'h1, `done`=0, state IDLE, prescaler=0, debouncer stable level=0, all synchroniser flops 0.
- **Input synchronisers**
  - `button` and `key_in` each pass through two flops.
  - `start` = synced `button` rising edge: a 3rd flop, `start` = s2 & ~s3.
  - A held button yields exactly one `start`.
- **Debouncer**
  - The synced key is compared to `key_stable`. If equal, the debounce counter clears to 0.
  - If different, the counter increments. When it reaches `DEBOUNCE_CYCLES`-1, `key_stable` takes the synced value and the counter clears.
  - `press` = one-cycle pulse on each 0→1 transition of `key_stable`. Releases produce nothing.
- **Prescaler**
  - Counts 0…`TICK_CYCLES`-1 while in RUN; holds at 0 otherwise.
  - `tick` = prescaler at `TICK_CYCLES`-1.
  - Cleared to 0 on `start`.
- **FSM**
  - **IDLE**: outputs hold their values.
    - `start` → RUN; `timer_out` and `count_out` set to 21'h1.
  - **RUN**:
    - `tick` → `timer_out` shifts left one place.
    - If the shifted value is bit 20, go to DONE on the same edge.
    - `press` → `count_out` shifts left one place; saturates at bit 20 (stays at bit 20, never wraps).
    - `start` → restart: both outputs 21'h1, prescaler 0, stay in RUN.
  - **DONE**: `done`=1; outputs frozen; `press` ignored.
    - `start` → RUN with both outputs 21'h1.
- **Simultaneous events**
  - `start` together with `tick` or `press`: `start` wins; both outputs are 21'h1 and the press is discarded.
  - `tick` to 20 together with `press`: both are applied on that edge, then DONE.
- **Invariant**: both outputs are exactly one-hot in every cycle, including during and after reset. The display decodes any other pattern incorrectly.
- **Reset mid-run**: immediate return to reset values; no pending `press` or `start` survives.

## Timing
- **`button` to RUN**:
  - `button` rising before edge k is captured in s1 at edge k.
  - `start` is high after edge k+1.
  - State = RUN and outputs = 21'h1 after edge k+2.
- **Timer steps**: the first timer step occurs `TICK_CYCLES` edges after the RUN entry edge; later steps every `TICK_CYCLES` edges. Value 20, and therefore DONE, is reached 20×`TICK_CYCLES` edges after RUN entry.
- **Key press to count**:
  - `key_in` goes high and stays stable before edge k.
  - `key_stable` rises at edge k+1+`DEBOUNCE_CYCLES`.
  - `press` is high in the following cycle.
  - `count_out` updates at edge k+2+`DEBOUNCE_CYCLES`.
- **Glitches**: any key glitch shorter than `DEBOUNCE_CYCLES` cycles of synced level produces no `press`.
- **Output registration**: all outputs are registered; there is no combinational path from any input to any output.

## Test plan
All scenarios use `TICK_CYCLES`=10 and `DEBOUNCE_CYCLES`=4.

1. **Reset**: drive `rst`=0 mid-run at an arbitrary phase → `timer_out`=21'h1, `count_out`=21'h1 and `done`=0 within the same cycle; state IDLE; no output change after release until `button`.
2. **Start and full run**: `button` high for 1 cycle → RUN 3 edges later. `timer_out` steps 21'h1→21'h2 after 10 edges and reaches 21'h100000 after 200 edges. `done`=1 on that edge; outputs are frozen for the next 50 cycles.
3. **Debounce**:
   - `key_in` toggles every 2 cycles for 20 cycles, then holds high → exactly one increment, `count_out`=21'h2.
   - A 3-cycle high pulse → no increment.
4. **Saturation**: 25 clean presses during RUN → `count_out` stops at 21'h100000; presses in DONE → no change.
5. **Collision**: `start` edge coincident with `tick` and a `press` → `timer_out`=21'h1, `count_out`=21'h1, prescaler restarts; the next step comes 10 edges later.
6. **Restart from DONE and held button**: `button` held high for 100 cycles → exactly one restart; the run proceeds normally and the one-hot check holds every cycle.

Source files
------------

// File: rtl/timer_count_gen.sv
// Elapsed-tick timer and debounced key-press counter feeding the left four display digits.
// Both values are carried one-hot (bit i set means value i) and saturate at MAX_VAL.
module timer_count_gen #(
    parameter int unsigned TICK_CYCLES     = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_VAL         = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic               key_in,
    output logic [MAX_VAL:0]   timer_out,
    output logic [MAX_VAL:0]   count_out,
    output logic               done
);

    localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [MAX_VAL:0] ValZero  = {{MAX_VAL{1'b0}}, 1'b1};

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic btn_s1_q, btn_s2_q, btn_s3_q;
    logic key_s1_q, key_s2_q;

    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           key_stable_q, key_stable_d;
    logic           key_stable_prev_q;

    logic [TickW-1:0] presc_q, presc_d;

    logic [1:0]       state_q, state_d;
    logic [MAX_VAL:0] timer_q, timer_d;
    logic [MAX_VAL:0] count_q, count_d;
    logic             done_q, done_d;

    logic start;
    logic press;
    logic tick;

    // Both inputs are asynchronous to clk; the third button flop gives edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            btn_s3_q <= 1'b0;
            key_s1_q <= 1'b0;
            key_s2_q <= 1'b0;
        end else begin
            btn_s1_q <= button;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            key_s1_q <= key_in;
            key_s2_q <= key_s1_q;
        end
    end

    assign start = btn_s2_q & ~btn_s3_q;

    always_comb begin
        db_cnt_d     = db_cnt_q;
        key_stable_d = key_stable_q;
        if (key_s2_q == key_stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            key_stable_d = key_s2_q;
            db_cnt_d     = '0;
        end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_q          <= '0;
            key_stable_q      <= 1'b0;
            key_stable_prev_q <= 1'b0;
        end else begin
            db_cnt_q          <= db_cnt_d;
            key_stable_q      <= key_stable_d;
            key_stable_prev_q <= key_stable_q;
        end
    end

    // Only accepted 0->1 transitions count; releases are silent.
    assign press = key_stable_q & ~key_stable_prev_q;

    assign tick = (state_q == StRun) && (presc_q == TickLast);

    always_comb begin
        presc_d = '0;
        if (!start && (state_q == StRun)) begin
            presc_d = tick ? '0 : presc_q + TickW'(1);
        end
    end

    // Start overrides any coincident tick or press.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        if (start) begin
            state_d = StRun;
            timer_d = ValZero;
            count_d = ValZero;
        end else if (state_q == StRun) begin
            if (tick) begin
                timer_d = {timer_q[MAX_VAL-1:0], 1'b0};
                if (timer_q[MAX_VAL-1]) begin
                    state_d = StDone;
                end
            end
            if (press && !count_q[MAX_VAL]) begin
                count_d = {count_q[MAX_VAL-1:0], 1'b0};
            end
        end
    end

    assign done_d = (state_d == StDone);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            state_q <= StIdle;
            timer_q <= ValZero;
            count_q <= ValZero;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign timer_out = timer_q;
    assign count_out = count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_timer_count_gen.sv
// Directed bench for timer_count_gen with TICK_CYCLES=10 and DEBOUNCE_CYCLES=4.
// Expected outputs are queued as stimulus is applied and compared when the step completes.
module tb_timer_count_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        button;
    logic        key_in;
    logic [20:0] timer_out;
    logic [20:0] count_out;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [20:0] t;
        logic [20:0] c;
        logic        d;
    } exp_t;

    exp_t sb[$];

    timer_count_gen #(
        .TICK_CYCLES    (10),
        .DEBOUNCE_CYCLES(4),
        .MAX_VAL        (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .key_in   (key_in),
        .timer_out(timer_out),
        .count_out(count_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] oh(input int i);
        logic [20:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic expect_out(input string tag, input int ti, input int ci, input logic d);
        exp_t e;
        e.tag = tag;
        e.t   = oh(ti);
        e.c   = oh(ci);
        e.d   = d;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty got size 0 expected >0");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks += 3;
            assert (timer_out === e.t) else begin
                failures++;
                $error("FAIL %s timer_out got %h expected %h", e.tag, timer_out, e.t);
            end
            assert (count_out === e.c) else begin
                failures++;
                $error("FAIL %s count_out got %h expected %h", e.tag, count_out, e.c);
            end
            assert (done === e.d) else begin
                failures++;
                $error("FAIL %s done got %b expected %b", e.tag, done, e.d);
            end
        end
    endtask

    // Advance n cycles, sampling on the falling edge and checking one-hot each cycle.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            checks++;
            assert ($onehot(timer_out) && $onehot(count_out)) else begin
                failures++;
                $error("FAIL onehot timer_out %h count_out %h expected one-hot", timer_out,
                       count_out);
            end
        end
    endtask

    task automatic press_key();
        key_in = 1'b1;
        cyc(5);
        key_in = 1'b0;
        cyc(4);
    endtask

    task automatic pulse_button();
        button = 1'b1;
        cyc(1);
        button = 1'b0;
        cyc(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected TB_RESULT");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        button = 1'b0;
        key_in = 1'b0;

        expect_out("reset", 0, 0, 1'b0);
        cyc(2);
        check_out();
        rst = 1'b1;

        // Key activity in IDLE must not count.
        expect_out("idle_press", 0, 0, 1'b0);
        key_in = 1'b1;
        cyc(8);
        key_in = 1'b0;
        cyc(8);
        check_out();

        // Full run: first step 10 edges after RUN entry, DONE at 200.
        expect_out("pre_step", 0, 0, 1'b0);
        pulse_button();
        cyc(9);
        check_out();
        expect_out("first_step", 1, 0, 1'b0);
        cyc(1);
        check_out();
        expect_out("step19", 19, 0, 1'b0);
        cyc(189);
        check_out();
        expect_out("done_reach", 20, 0, 1'b1);
        cyc(1);
        check_out();
        expect_out("done_frozen", 20, 0, 1'b1);
        cyc(50);
        check_out();

        // Saturation: 25 presses in RUN, then presses in DONE.
        expect_out("sat_restart", 0, 0, 1'b0);
        pulse_button();
        check_out();
        expect_out("sat_mid", 9, 10, 1'b0);
        for (int i = 0; i < 10; i++) press_key();
        check_out();
        expect_out("sat_full", 20, 20, 1'b1);
        for (int i = 0; i < 15; i++) press_key();
        check_out();
        expect_out("done_press", 20, 20, 1'b1);
        for (int i = 0; i < 3; i++) press_key();
        check_out();

        // Held button restarts from DONE once; debounce runs meanwhile.
        expect_out("held_restart", 0, 0, 1'b0);
        button = 1'b1;
        cyc(3);
        check_out();
        expect_out("bounce", 2, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            key_in = (i % 2 == 0);
            cyc(2);
        end
        check_out();
        expect_out("bounce_settle", 2, 1, 1'b0);
        key_in = 1'b1;
        cyc(8);
        check_out();
        expect_out("release", 3, 1, 1'b0);
        key_in = 1'b0;
        cyc(8);
        check_out();
        expect_out("glitch3", 4, 1, 1'b0);
        key_in = 1'b1;
        cyc(3);
        key_in = 1'b0;
        cyc(8);
        check_out();
        expect_out("held_no_restart", 9, 1, 1'b0);
        cyc(50);
        button = 1'b0;
        check_out();
        expect_out("held_done", 20, 1, 1'b1);
        cyc(103);
        check_out();

        // Collision: start, tick and press all land on RUN-entry + 30.
        expect_out("col_restart", 0, 0, 1'b0);
        pulse_button();
        check_out();
        expect_out("col_before", 2, 0, 1'b0);
        cyc(23);
        key_in = 1'b1;
        cyc(4);
        button = 1'b1;
        cyc(1);
        button = 1'b0;
        check_out();
        expect_out("collision", 0, 0, 1'b0);
        cyc(2);
        check_out();
        expect_out("col_pre_step", 0, 0, 1'b0);
        cyc(9);
        check_out();
        expect_out("col_step", 1, 0, 1'b0);
        cyc(1);
        check_out();

        // Asynchronous reset mid-run, mid-cycle.
        expect_out("pre_reset", 2, 1, 1'b0);
        key_in = 1'b0;
        cyc(6);
        key_in = 1'b1;
        cyc(8);
        check_out();
        expect_out("async_reset", 0, 0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check_out();
        cyc(1);
        rst = 1'b1;
        expect_out("idle_after_reset", 0, 0, 1'b0);
        cyc(30);
        check_out();
        expect_out("rerun_step", 1, 0, 1'b0);
        pulse_button();
        cyc(10);
        check_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
